pulse_pattern_gen: RTL and testbench
====================================

// Module: pulse_pattern_gen
// PURPOSE
//  Upstream stimulus stage. Drives the single-bit pattern signal 'a' that the
//  downstream assertion-checked logic samples on posedge clk.
//  Emits num_pulses high pulses of high_len cycles, separated by low_len low cycles.
//  Provides busy/done status and a registered rise strobe for edge checkers.
// PARAMETERS
//  CNT_W  8  width of high_len / low_len phase counters
//  PN_W   8  width of num_pulses / remaining-pulse counter
// PORTS
//  clk         in   1      single clock; all logic on posedge clk
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request a pattern; sampled only in IDLE
//  high_len    in   CNT_W  high-phase length in cycles; latched on accepted start
//  low_len     in   CNT_W  low-phase length in cycles; latched on accepted start
//  num_pulses  in   PN_W   pulses to emit; latched on accepted start
//  abort       in   1      present only with PULSE_GEN_ABORT_EN
//  a           out  1      pattern output, registered
//  rise        out  1      1 exactly in cycles where a went 0->1, registered
//  busy        out  1      1 while in HIGH or LOW
//  done        out  1      one-cycle completion strobe
// BEHAVIOUR
//  - Reset (async, immediate): a=0, rise=0, busy=0, done=0, state=IDLE, counters=0.
//  - States: IDLE, HIGH, LOW. done is a strobe, not a state.
//  - IDLE, start=1, num_pulses!=0, high_len!=0:
//    - latch inputs; next cycle state=HIGH, a=1, rise=1, busy=1.
//    - Latency start->a: 1 cycle.
//  - IDLE, start=1, num_pulses==0 or high_len==0:
//    - next cycle done=1 for 1 cycle; a stays 0, busy stays 0.
//  - HIGH: a=1 for exactly high_len cycles.
//    - Then, if remaining>1: go to LOW and decrement remaining.
//    - Else: next cycle a=0, busy=0, done=1, state=IDLE.
//  - LOW: a=0 for max(low_len,1) cycles.
//    - low_len==0 is treated as 1, so every pulse has a visible rising edge.
//    - Then HIGH with rise=1.
//  - rise=0 in every other cycle; never 1 in two consecutive cycles.
//  - start while busy: ignored; latched values are unchanged mid-pattern.
//  - start in the done cycle: accepted (state is IDLE). a rises next cycle after one low cycle.
//  - Counters are down-counters reloaded from the latched lengths; no wrap at max values.
//    - high_len = 2^CNT_W-1 gives exactly that many high cycles.
//  - rst mid-pattern: outputs go to reset values at once; the pattern is lost and done does not fire.
// CONFIGURATION
//  PULSE_GEN_ABORT_EN defined:
//   - abort port exists.
//   - abort=1 in HIGH or LOW: next cycle a=0, rise=0, busy=0, done=0, state=IDLE.
//   - abort=1 in IDLE: ignored, except that start in the same cycle is dropped (abort wins).
//  PULSE_GEN_ABORT_EN not defined: no abort port; a pattern ends only by completion or rst.
// TESTING
//  1 rst=1 at t=3ns (mid-cycle) -> a=0, busy=0, done=0, rise=0 before the next posedge.
//  2 start @c0, high=2, low=3, num=3:
//    - a=1 @c1-2, c6-7, c11-12; rise @c1, c6, c11.
//    - done=1 @c13 only; busy=1 @c1-12.
//  3 start, high=1, low=0, num=4:
//    - a=1,0,1,0,1,0,1 over c1-c7; exactly 4 rise strobes.
//    - done @c8.
//  4 start with num=0 (then high=0, num=5) -> done=1 one cycle later; a, rise, busy stay 0.
//  5 start @c0 (high=4, low=4, num=2); start again @c2 -> ignored, pattern identical to single start.
//    - rst pulse @c3 -> a=0 at once, no done; fresh start afterwards runs normally.
//  6 [PULSE_GEN_ABORT_EN] high=2, low=3, num=3; abort @c4 (LOW):
//    - @c5: busy=0, a=0; no further rise; done never asserts.

Source files
------------

// File: rtl/pulse_pattern_gen.sv
// rtl/pulse_pattern_gen.sv - programmable high/low pulse train generator with busy/done/rise status.
// Optional abort input enabled by defining PULSE_GEN_ABORT_EN.
module pulse_pattern_gen #(
  parameter int CNT_W = 8,
  parameter int PN_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [PN_W-1:0]  num_pulses,
`ifdef PULSE_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             a,
  output logic             rise,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [PN_W-1:0]  r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_high_len, r_low_len;
  logic             w_abort, w_accept, w_empty, w_last_high;
  logic [CNT_W-1:0] w_low_load;
  logic             w_a_nxt, w_rise_nxt, w_busy_nxt, w_done_nxt;

`ifdef PULSE_GEN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept    = start && !w_abort && (num_pulses != '0) && (high_len != '0);
  assign w_empty     = start && !w_abort && ((num_pulses == '0) || (high_len == '0));
  // A zero low phase still needs one low cycle so each pulse shows a rising edge.
  assign w_low_load  = (r_low_len == '0) ? CNT_W'(1) : r_low_len;
  assign w_last_high = (r_cnt == CNT_W'(1)) && (r_rem <= PN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_high_len <= '0;
      r_low_len  <= '0;
      a          <= 1'b0;
      rise       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      if (r_state == S_IDLE && w_accept) begin
        r_high_len <= high_len;
        r_low_len  <= low_len;
      end
      a    <= w_a_nxt;
      rise <= w_rise_nxt;
      busy <= w_busy_nxt;
      done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = high_len;
          w_rem_nxt   = num_pulses;
        end
      end
      S_HIGH: begin
        if (w_abort || w_last_high) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_rem_nxt   = '0;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = w_low_load;
          w_rem_nxt   = r_rem - PN_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_rem_nxt   = '0;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = r_high_len;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_rem_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_a_nxt    = (w_state_nxt == S_HIGH);
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_rise_nxt = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);
    w_done_nxt = ((r_state == S_IDLE) && w_empty) ||
                 ((r_state == S_HIGH) && !w_abort && w_last_high);
  end

endmodule

// File: tb/tb_pulse_pattern_gen.sv
// tb/tb_pulse_pattern_gen.sv - directed self-checking bench for pulse_pattern_gen.
module tb_pulse_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [7:0] num_pulses = '0;
  logic       abort = 1'b0;
  logic       a, rise, busy, done;

  int checks = 0;
  int failures = 0;
  logic [15:0] oa, orr, ob, od;

  always #5 clk = ~clk;

  pulse_pattern_gen #(.CNT_W(8), .PN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .high_len(high_len), .low_len(low_len), .num_pulses(num_pulses),
`ifdef PULSE_GEN_ABORT_EN
    .abort(abort),
`endif
    .a(a), .rise(rise), .busy(busy), .done(done)
  );

  task automatic issue(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
    @(negedge clk);
    high_len = h; low_len = l; num_pulses = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    #3 rst = 1'b1;
    #1;
    checks++; if (a !== 1'b0)    begin failures++; $display("FAIL reset_a got=%b exp=0", a); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rise !== 1'b0) begin failures++; $display("FAIL reset_rise got=%b exp=0", rise); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic;
    oa = '0; orr = '0; ob = '0; od = '0;
    issue(8'd2, 8'd3, 8'd3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      oa[k-1] = a; orr[k-1] = rise; ob[k-1] = busy; od[k-1] = done;
    end
    checks++; if (oa  !== 16'h0C63) begin failures++; $display("FAIL basic_a got=%h exp=0c63", oa); end
    checks++; if (orr !== 16'h0421) begin failures++; $display("FAIL basic_rise got=%h exp=0421", orr); end
    checks++; if (ob  !== 16'h0FFF) begin failures++; $display("FAIL basic_busy got=%h exp=0fff", ob); end
    checks++; if (od  !== 16'h1000) begin failures++; $display("FAIL basic_done got=%h exp=1000", od); end
  endtask

  task automatic test_low_zero;
    oa = '0; orr = '0; ob = '0; od = '0;
    issue(8'd1, 8'd0, 8'd4);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      oa[k-1] = a; orr[k-1] = rise; ob[k-1] = busy; od[k-1] = done;
    end
    checks++; if (oa  !== 16'h0055) begin failures++; $display("FAIL lowzero_a got=%h exp=0055", oa); end
    checks++; if (orr !== 16'h0055) begin failures++; $display("FAIL lowzero_rise got=%h exp=0055", orr); end
    checks++; if (ob  !== 16'h007F) begin failures++; $display("FAIL lowzero_busy got=%h exp=007f", ob); end
    checks++; if (od  !== 16'h0080) begin failures++; $display("FAIL lowzero_done got=%h exp=0080", od); end
  endtask

  task automatic test_empty;
    for (int t = 0; t < 2; t++) begin
      oa = '0; orr = '0; ob = '0; od = '0;
      if (t == 0) issue(8'd3, 8'd1, 8'd0);
      else        issue(8'd0, 8'd1, 8'd5);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        oa[k-1] = a; orr[k-1] = rise; ob[k-1] = busy; od[k-1] = done;
      end
      checks++; if (od !== 16'h0001) begin failures++; $display("FAIL empty%0d_done got=%h exp=0001", t, od); end
      checks++; if ((oa | orr | ob) !== 16'h0000) begin
        failures++; $display("FAIL empty%0d_quiet a=%h rise=%h busy=%h exp=0000", t, oa, orr, ob);
      end
    end
  endtask

  task automatic test_ignore_and_reset;
    int seen_done;
    oa = '0; orr = '0; ob = '0; od = '0;
    issue(8'd4, 8'd4, 8'd2);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      oa[k-1] = a; orr[k-1] = rise; ob[k-1] = busy; od[k-1] = done;
      if (k == 2) begin high_len = 8'd1; low_len = 8'd0; num_pulses = 8'd9; start = 1'b1; end
      if (k == 3) start = 1'b0;
    end
    checks++; if (oa  !== 16'h0F0F) begin failures++; $display("FAIL ignore_a got=%h exp=0f0f", oa); end
    checks++; if (orr !== 16'h0101) begin failures++; $display("FAIL ignore_rise got=%h exp=0101", orr); end
    checks++; if (ob  !== 16'h0FFF) begin failures++; $display("FAIL ignore_busy got=%h exp=0fff", ob); end
    checks++; if (od  !== 16'h1000) begin failures++; $display("FAIL ignore_done got=%h exp=1000", od); end

    issue(8'd4, 8'd4, 8'd2);
    for (int k = 1; k <= 3; k++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (a !== 1'b0)    begin failures++; $display("FAIL midrst_a got=%b exp=0", a); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(negedge clk) rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 || a === 1'b1) seen_done++;
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", seen_done); end

    oa = '0; od = '0;
    issue(8'd1, 8'd1, 8'd2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      oa[k-1] = a; od[k-1] = done;
    end
    checks++; if (oa !== 16'h0005) begin failures++; $display("FAIL afterrst_a got=%h exp=0005", oa); end
    checks++; if (od !== 16'h0008) begin failures++; $display("FAIL afterrst_done got=%h exp=0008", od); end
  endtask

  task automatic test_back_to_back;
    oa = '0; orr = '0; ob = '0; od = '0;
    issue(8'd1, 8'd0, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      oa[k-1] = a; orr[k-1] = rise; ob[k-1] = busy; od[k-1] = done;
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
    end
    checks++; if (oa  !== 16'h0005) begin failures++; $display("FAIL b2b_a got=%h exp=0005", oa); end
    checks++; if (orr !== 16'h0005) begin failures++; $display("FAIL b2b_rise got=%h exp=0005", orr); end
    checks++; if (ob  !== 16'h0005) begin failures++; $display("FAIL b2b_busy got=%h exp=0005", ob); end
    checks++; if (od  !== 16'h000A) begin failures++; $display("FAIL b2b_done got=%h exp=000a", od); end
  endtask

  task automatic test_max_len;
    int high_cycles, done_at;
    high_cycles = 0; done_at = -1;
    issue(8'd255, 8'd0, 8'd1);
    for (int k = 1; k <= 258; k++) begin
      @(negedge clk);
      if (a === 1'b1) high_cycles++;
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    checks++; if (high_cycles !== 255) begin failures++; $display("FAIL max_high got=%0d exp=255", high_cycles); end
    checks++; if (done_at !== 256) begin failures++; $display("FAIL max_done got=%0d exp=256", done_at); end
  endtask

`ifdef PULSE_GEN_ABORT_EN
  task automatic test_abort;
    oa = '0; orr = '0; ob = '0; od = '0;
    issue(8'd2, 8'd3, 8'd3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      oa[k-1] = a; orr[k-1] = rise; ob[k-1] = busy; od[k-1] = done;
      if (k == 4) abort = 1'b1;
      if (k == 5) abort = 1'b0;
    end
    checks++; if (oa  !== 16'h0003) begin failures++; $display("FAIL abort_a got=%h exp=0003", oa); end
    checks++; if (orr !== 16'h0001) begin failures++; $display("FAIL abort_rise got=%h exp=0001", orr); end
    checks++; if (ob  !== 16'h000F) begin failures++; $display("FAIL abort_busy got=%h exp=000f", ob); end
    checks++; if (od  !== 16'h0000) begin failures++; $display("FAIL abort_done got=%h exp=0000", od); end
    oa = '0; ob = '0; od = '0;
    @(negedge clk);
    abort = 1'b1;
    issue(8'd0, 8'd1, 8'd0);
    abort = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      oa[k-1] = a; ob[k-1] = busy; od[k-1] = done;
    end
    checks++; if ((oa | ob | od) !== 16'h0000) begin
      failures++; $display("FAIL abort_idle a=%h busy=%h done=%h exp=0000", oa, ob, od);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_low_zero;
    test_empty;
    test_ignore_and_reset;
    test_back_to_back;
    test_max_len;
`ifdef PULSE_GEN_ABORT_EN
    test_abort;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
